// File: rtl/if_fetch_unit.sv
// if_fetch_unit: DLX instruction-fetch stage feeding the IF/ID register and stalling the PC.
module if_fetch_unit #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0,
    parameter int                MAX_WAIT  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              flush,
    input  logic              id_stall,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_rdy,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              fetch_stall,
    output logic [DATA_W-1:0] IF_ID_instr,
    output logic [DATA_W-1:0] IF_ID_PC4,
    output logic              IF_ID_valid,
    output logic              timeout_err
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;
    localparam logic [7:0] maxCnt = 8'(MAX_WAIT);
    state_t state, nextState;
    logic [DATA_W-1:0] holdInstr, holdPc4, drainAddr, pc4;
    logic [7:0] waitCnt;
    logic xfer, waiting;
    assign pc4 = pc_in + DATA_W'(4);
    assign xfer = imem_req && imem_rdy;
    assign waiting = imem_req && !imem_rdy;
    always_ff @(posedge clk)
        state <= reset ? IDLE : nextState;
    always_comb begin
        nextState = state;
        imem_req = 1'b0;
        imem_addr = pc_in;
        fetch_stall = 1'b1;
        case (state)
            IDLE: nextState = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                fetch_stall = !imem_rdy || id_stall;
                nextState = flush ? (imem_rdy ? FETCH : DRAIN) : (imem_rdy && id_stall ? HOLD : FETCH);
            end
            HOLD: nextState = (flush || !id_stall) ? FETCH : HOLD;
            DRAIN: begin
                imem_req = 1'b1;
                imem_addr = drainAddr;
                nextState = (!flush && imem_rdy) ? FETCH : DRAIN;
            end
            default: nextState = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            IF_ID_instr <= NOP_INSTR;
            IF_ID_PC4 <= '0;
            IF_ID_valid <= 1'b0;
            holdInstr <= NOP_INSTR;
            holdPc4 <= '0;
            drainAddr <= '0;
        end else if (flush) begin
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
            holdInstr <= NOP_INSTR;
            holdPc4 <= '0;
            if (state == FETCH && !imem_rdy)
                drainAddr <= pc_in;
        end else if (state == FETCH) begin
            if (imem_rdy && !id_stall) begin
                IF_ID_instr <= imem_rdata;
                IF_ID_PC4 <= pc4;
                IF_ID_valid <= 1'b1;
            end else if (imem_rdy) begin
                holdInstr <= imem_rdata;
                holdPc4 <= pc4;
            end else if (!id_stall) begin
                IF_ID_instr <= NOP_INSTR;
                IF_ID_valid <= 1'b0;
            end
        end else if (state == HOLD && !id_stall) begin
            IF_ID_instr <= holdInstr;
            IF_ID_PC4 <= holdPc4;
            IF_ID_valid <= 1'b1;
        end
    end
    // Counter saturates at MAX_WAIT; the error flag stays set until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            waitCnt <= '0;
            timeout_err <= 1'b0;
        end else begin
            waitCnt <= (xfer || (flush && state == FETCH)) ? '0 :
                       (waiting && waitCnt != maxCnt) ? waitCnt + 8'd1 : waitCnt;
            if (waiting && waitCnt >= maxCnt - 8'd1)
                timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed vectors for if_fetch_unit against a memory returning ~address.
module tb_if_fetch_unit;
    logic clk = 1'b0;
    logic reset, flush, id_stall, imem_rdy;
    logic [31:0] pc_in, imem_rdata, imem_addr, IF_ID_instr, IF_ID_PC4;
    logic imem_req, fetch_stall, IF_ID_valid, timeout_err;
    int nVec = 0;
    int nBad = 0;

    if_fetch_unit dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .flush(flush), .id_stall(id_stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_rdata(imem_rdata),
        .fetch_stall(fetch_stall), .IF_ID_instr(IF_ID_instr), .IF_ID_PC4(IF_ID_PC4),
        .IF_ID_valid(IF_ID_valid), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    assign imem_rdata = ~imem_addr;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; id_stall = 1'b0; imem_rdy = 1'b0; pc_in = 32'h0;
        tick(); tick();
        checkVal("rst_valid", 32'(IF_ID_valid), 32'd0);
        checkVal("rst_instr", IF_ID_instr, 32'h0);
        checkVal("rst_pc4", IF_ID_PC4, 32'h0);
        checkVal("rst_timeout", 32'(timeout_err), 32'd0);
        checkVal("rst_req", 32'(imem_req), 32'd0);
        checkVal("rst_stall", 32'(fetch_stall), 32'd1);
        // IDLE cycle, then back-to-back fetches
        reset = 1'b0; imem_rdy = 1'b1; pc_in = 32'h0040_0000;
        #1;
        checkVal("idle_req", 32'(imem_req), 32'd0);
        checkVal("idle_stall", 32'(fetch_stall), 32'd1);
        tick();
        checkVal("idle_valid", 32'(IF_ID_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            pc_in = 32'h0040_0000 + 32'(4 * i);
            #1;
            checkVal("seq_stall", 32'(fetch_stall), 32'd0);
            checkVal("seq_req", 32'(imem_req), 32'd1);
            checkVal("seq_addr", imem_addr, 32'h0040_0000 + 32'(4 * i));
            tick();
            checkVal("seq_valid", 32'(IF_ID_valid), 32'd1);
            checkVal("seq_pc4", IF_ID_PC4, 32'h0040_0004 + 32'(4 * i));
            checkVal("seq_instr", IF_ID_instr, ~(32'h0040_0000 + 32'(4 * i)));
        end
        // memory wait: three bubbles
        pc_in = 32'h0040_0010; imem_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkVal("wait_stall", 32'(fetch_stall), 32'd1);
            tick();
            checkVal("wait_valid", 32'(IF_ID_valid), 32'd0);
            checkVal("wait_instr", IF_ID_instr, 32'h0);
        end
        imem_rdy = 1'b1;
        tick();
        checkVal("wait_pc4", IF_ID_PC4, 32'h0040_0014);
        checkVal("wait_done_valid", 32'(IF_ID_valid), 32'd1);
        checkVal("wait_timeout", 32'(timeout_err), 32'd0);
        // decode stall: word parked in hold buffer
        pc_in = 32'h0040_0018; id_stall = 1'b1;
        tick();
        checkVal("hold_req", 32'(imem_req), 32'd0);
        checkVal("hold_stall", 32'(fetch_stall), 32'd1);
        checkVal("hold_pc4", IF_ID_PC4, 32'h0040_0014);
        tick();
        checkVal("hold2_pc4", IF_ID_PC4, 32'h0040_0014);
        checkVal("hold2_valid", 32'(IF_ID_valid), 32'd1);
        id_stall = 1'b0;
        tick();
        checkVal("release_pc4", IF_ID_PC4, 32'h0040_001C);
        checkVal("release_instr", IF_ID_instr, ~32'h0040_0018);
        pc_in = 32'h0040_001C;
        #1;
        checkVal("release_req", 32'(imem_req), 32'd1);
        tick();
        checkVal("after_hold_pc4", IF_ID_PC4, 32'h0040_0020);
        // flush while memory not ready: drain the old address
        pc_in = 32'h0040_0008; imem_rdy = 1'b0; flush = 1'b1;
        tick();
        checkVal("flush_valid", 32'(IF_ID_valid), 32'd0);
        flush = 1'b0; pc_in = 32'h0040_0220;
        #1;
        checkVal("drain_addr", imem_addr, 32'h0040_0008);
        checkVal("drain_req", 32'(imem_req), 32'd1);
        checkVal("drain_stall", 32'(fetch_stall), 32'd1);
        tick();
        checkVal("drain_addr2", imem_addr, 32'h0040_0008);
        imem_rdy = 1'b1;
        tick();
        checkVal("drain_done_valid", 32'(IF_ID_valid), 32'd0);
        checkVal("branch_addr", imem_addr, 32'h0040_0220);
        checkVal("branch_stall", 32'(fetch_stall), 32'd0);
        tick();
        checkVal("branch_pc4", IF_ID_PC4, 32'h0040_0224);
        checkVal("branch_valid", 32'(IF_ID_valid), 32'd1);
        // flush together with an accepted word
        pc_in = 32'h0040_0300; flush = 1'b1;
        tick();
        checkVal("flushrdy_valid", 32'(IF_ID_valid), 32'd0);
        checkVal("flushrdy_instr", IF_ID_instr, 32'h0);
        flush = 1'b0; pc_in = 32'h0040_0400;
        #1;
        checkVal("flushrdy_addr", imem_addr, 32'h0040_0400);
        tick();
        checkVal("flushrdy_pc4", IF_ID_PC4, 32'h0040_0404);
        // flush while holding a word
        pc_in = 32'h0040_0500; id_stall = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        checkVal("flushhold_valid", 32'(IF_ID_valid), 32'd0);
        flush = 1'b0; id_stall = 1'b0; pc_in = 32'h0040_0600;
        #1;
        checkVal("flushhold_req", 32'(imem_req), 32'd1);
        tick();
        checkVal("flushhold_pc4", IF_ID_PC4, 32'h0040_0604);
        checkVal("flushhold_instr", IF_ID_instr, ~32'h0040_0600);
        // timeout after MAX_WAIT waiting cycles
        pc_in = 32'h0040_0700; imem_rdy = 1'b0;
        repeat (15) tick();
        checkVal("timeout_15", 32'(timeout_err), 32'd0);
        tick();
        checkVal("timeout_16", 32'(timeout_err), 32'd1);
        imem_rdy = 1'b1;
        tick();
        checkVal("timeout_xfer_valid", 32'(IF_ID_valid), 32'd1);
        checkVal("timeout_sticky", 32'(timeout_err), 32'd1);
        // reset mid-request, then PC+4 wrap
        imem_rdy = 1'b0; reset = 1'b1;
        tick();
        checkVal("rst2_timeout", 32'(timeout_err), 32'd0);
        checkVal("rst2_req", 32'(imem_req), 32'd0);
        checkVal("rst2_valid", 32'(IF_ID_valid), 32'd0);
        reset = 1'b0;
        tick();
        pc_in = 32'hFFFF_FFFC; imem_rdy = 1'b1;
        tick();
        checkVal("wrap_pc4", IF_ID_PC4, 32'h0);
        checkVal("wrap_instr", IF_ID_instr, 32'h3);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end
endmodule
